// File: rtl/crc_engine_pkg.sv
// Shared definitions for the streaming CRC engine: FSM state encoding,
// the CRC-32 constants used as parameter defaults, and a generic
// MSB-first, non-reflected CRC update function.
package crc_engine_pkg;

    // Widest CRC register the update function can handle.
    localparam int CRC_MAX_W = 64;

    // CRC-32 (MSB-first, non-reflected) generator, seed and good-frame residue.
    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

    // Frame sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PASS   = 2'd1,
        APPEND = 2'd2
    } state_t;

    // One data_w-bit update of a crc_w-bit register: the data is XORed into
    // the top data_w bits, then data_w shifts through poly are applied.
    // Operands are right-aligned in CRC_MAX_W-bit containers.
    function automatic logic [CRC_MAX_W-1:0] crc_update(
        input logic [CRC_MAX_W-1:0] crc_in,
        input logic [CRC_MAX_W-1:0] data,
        input logic [CRC_MAX_W-1:0] poly,
        input int                   crc_w,
        input int                   data_w
    );
        logic [CRC_MAX_W-1:0] mask;
        logic [CRC_MAX_W-1:0] top_bit;
        logic [CRC_MAX_W-1:0] c;
        logic                 msb;
        mask    = (crc_w >= CRC_MAX_W) ? '1
                                       : ((CRC_MAX_W'(1) << crc_w) - CRC_MAX_W'(1));
        top_bit = CRC_MAX_W'(1) << (crc_w - 1);
        c       = (crc_in ^ (data << (crc_w - data_w))) & mask;
        for (int i = 0; i < data_w; i++) begin
            msb = |(c & top_bit);
            c   = (c << 1) & mask;
            if (msb) begin
                c = c ^ (poly & mask);
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_engine_step.sv
// Combinational single-beat CRC update: folds one DATA_W-bit beat into a
// CRC_W-bit register through generator POLY (MSB-first, non-reflected).
// CRC_W must be a multiple of DATA_W and no wider than CRC_MAX_W.
module crc_engine_step
    import crc_engine_pkg::*;
#(
    parameter int               CRC_W  = 32,
    parameter int               DATA_W = 8,
    parameter logic [CRC_W-1:0] POLY   = CRC32_POLY
) (
    input  logic [CRC_W-1:0]  crc_in,
    input  logic [DATA_W-1:0] data,
    output logic [CRC_W-1:0]  crc_out
);

    // Whole DATA_W-bit update unrolled into one cycle of logic.
    always_comb begin
        crc_out = CRC_W'(crc_update(CRC_MAX_W'(crc_in), CRC_MAX_W'(data),
                                    CRC_MAX_W'(POLY), CRC_W, DATA_W));
    end

endmodule

// File: rtl/crc_engine.sv
// Streaming CRC engine with one registered output stage.
// append=1 on the first beat: the frame is forwarded and ~crc is appended
// as CRC_W/DATA_W beats, most significant chunk first.
// append=0: the frame is forwarded unchanged so its CRC can be checked.
// Optional macro CRC_ENGINE_CHECK_EN builds the residue compare that drives
// the crc_ok / crc_err pulses; without it both outputs are tied low.
module crc_engine
    import crc_engine_pkg::*;
#(
    parameter int               CRC_W   = 32,
    parameter int               DATA_W  = 8,
    parameter logic [CRC_W-1:0] POLY    = CRC32_POLY,
    parameter logic [CRC_W-1:0] INIT    = '1,
    parameter logic [CRC_W-1:0] RESIDUE = CRC32_RESIDUE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic              append,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [CRC_W-1:0]  crc,
    output logic              busy,
    output logic              crc_ok,
    output logic              crc_err
);

    localparam int NBEATS = CRC_W / DATA_W;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    state_t              state;
    state_t              state_next;
    logic [CRC_W-1:0]    crc_q;
    logic [CRC_W-1:0]    crc_base;
    logic [CRC_W-1:0]    crc_step;
    logic [CRC_W-1:0]    crc_inv;
    logic [DATA_W-1:0]   chunk;
    logic [CNT_W-1:0]    cnt;
    logic                mode_q;
    logic                mode_now;
    logic                out_free;
    logic                s_fire;
    logic                m_fire;
    logic                last_chunk;

    // The output slot can take a new beat when empty or being drained.
    assign out_free = !m_valid || m_ready;
    assign s_ready  = (state != APPEND) && out_free;
    assign s_fire   = s_valid && s_ready;
    assign m_fire   = m_valid && m_ready;

    // The mode is taken live on the first beat and held for the rest of the frame.
    assign mode_now = (state == IDLE) ? append : mode_q;

    // A new frame always starts from INIT, even if the register still shows
    // the previous check-mode result for one cycle.
    assign crc_base = (state == IDLE) ? INIT : crc_q;

    assign crc  = crc_q;
    assign busy = (state != IDLE);

    crc_engine_step #(
        .CRC_W  (CRC_W),
        .DATA_W (DATA_W),
        .POLY   (POLY)
    ) u_step (
        .crc_in  (crc_base),
        .data    (s_data),
        .crc_out (crc_step)
    );

    assign crc_inv    = ~crc_q;
    assign last_chunk = (cnt == CNT_W'(NBEATS - 1));

    // Select the CRC chunk addressed by the counter, most significant first.
    always_comb begin
        chunk = '0;
        for (int i = 0; i < NBEATS; i++) begin
            if (cnt == CNT_W'(i)) begin
                chunk = crc_inv[CRC_W-1-i*DATA_W -: DATA_W];
            end
        end
    end

    // Next-state logic for frame sequencing.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (s_fire) begin
                    if (s_last) begin
                        state_next = append ? APPEND : IDLE;
                    end else begin
                        state_next = PASS;
                    end
                end
            end
            PASS: begin
                if (s_fire && s_last) begin
                    state_next = mode_q ? APPEND : IDLE;
                end
            end
            APPEND: begin
                if (m_fire && m_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Output register, CRC register, mode latch and append chunk counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q   <= INIT;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            cnt     <= '0;
            mode_q  <= 1'b0;
        end else if (state == APPEND) begin
            if (m_fire) begin
                if (m_last) begin
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                    cnt     <= '0;
                    crc_q   <= INIT;
                end else begin
                    m_data <= chunk;
                    m_last <= last_chunk;
                    cnt    <= cnt + CNT_W'(1);
                end
            end
        end else if (s_fire) begin
            m_valid <= 1'b1;
            m_data  <= s_data;
            m_last  <= s_last && !mode_now;
            crc_q   <= crc_step;
            cnt     <= '0;
            if (state == IDLE) begin
                mode_q <= append;
            end
        end else begin
            if (m_fire) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
            if (state == IDLE) begin
                crc_q <= INIT;
            end
        end
    end

`ifdef CRC_ENGINE_CHECK_EN
    logic ok_q;
    logic err_q;

    // One-cycle verdict after the final beat of a check-mode frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ok_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ok_q  <= s_fire && s_last && !mode_now && (crc_step == RESIDUE);
            err_q <= s_fire && s_last && !mode_now && (crc_step != RESIDUE);
        end
    end

    assign crc_ok  = ok_q;
    assign crc_err = err_q;
`else
    assign crc_ok  = 1'b0;
    assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_crc_engine.sv
// Self-checking bench for crc_engine: an 8-bit-beat instance for the
// append/check/stall/reset scenarios and a 32-bit-beat instance for the
// single-beat append frame. Expected output beats go into scoreboards when
// input beats are accepted and are compared as the DUT emits them.
module tb_crc_engine;

`ifdef CRC_ENGINE_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    localparam logic [31:0] POLY    = 32'h04C11DB7;
    localparam logic [31:0] INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] RESIDUE = 32'hC704DD7B;

    logic        clk;
    logic        reset_n;

    logic        s_valid, s_ready, s_last, append;
    logic [7:0]  s_data;
    logic        m_valid, m_ready, m_last;
    logic [7:0]  m_data;
    logic [31:0] crc;
    logic        busy, crc_ok, crc_err;

    logic        w_s_valid, w_s_ready, w_s_last, w_append;
    logic [31:0] w_s_data;
    logic        w_m_valid, w_m_ready, w_m_last;
    logic [31:0] w_m_data;
    logic [31:0] w_crc;
    logic        w_busy, w_crc_ok, w_crc_err;

    int          checks   = 0;
    int          failures = 0;

    logic [8:0]  sb8[$];
    logic [32:0] sb32[$];
    logic [7:0]  frame8[$];

    int          pops8;
    int          ok_cnt, err_cnt;
    int          stall_pct;
    bit          in_append;
    bit          post_last;
    logic        cur_ap;
    logic [31:0] cur_reg;
    logic        cur_ok, cur_err;

    crc_engine #(.CRC_W(32), .DATA_W(8)) dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .append  (append),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .crc     (crc),
        .busy    (busy),
        .crc_ok  (crc_ok),
        .crc_err (crc_err)
    );

    crc_engine #(.CRC_W(32), .DATA_W(32)) dut32 (
        .clk     (clk),
        .reset_n (reset_n),
        .s_valid (w_s_valid),
        .s_ready (w_s_ready),
        .s_data  (w_s_data),
        .s_last  (w_s_last),
        .append  (w_append),
        .m_valid (w_m_valid),
        .m_ready (w_m_ready),
        .m_data  (w_m_data),
        .m_last  (w_m_last),
        .crc     (w_crc),
        .busy    (w_busy),
        .crc_ok  (w_crc_ok),
        .crc_err (w_crc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit-serial reference: feeds nbits of d, MSB first, into register c.
    function automatic logic [31:0] ref_crc(input logic [31:0] c_in, input logic [31:0] d, input int nbits);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int i = nbits - 1; i >= 0; i--) begin
            fb = c[31] ^ d[i];
            c  = {c[30:0], 1'b0};
            if (fb) c = c ^ POLY;
        end
        return c;
    endfunction

    function automatic logic [31:0] ref_frame();
        logic [31:0] c;
        c = INIT;
        for (int i = 0; i < frame8.size(); i++) c = ref_crc(c, {24'b0, frame8[i]}, 8);
        return c;
    endfunction

    // One clock of the 8-bit instance: drive, settle, check, score.
    task automatic cycle8(input logic sv, input logic [7:0] sd, input logic sl, output logic acc);
        logic [8:0]  e;
        logic [31:0] inv;
        @(negedge clk);
        s_valid = sv;
        s_data  = sd;
        s_last  = sl;
        append  = cur_ap;
        m_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
        #1;
        if (post_last) begin
            check("crc_at_last", crc, cur_reg);
            check("crc_ok_pulse", crc_ok, cur_ok);
            check("crc_err_pulse", crc_err, cur_err);
            post_last = 0;
        end
        if (crc_ok)  ok_cnt++;
        if (crc_err) err_cnt++;
        if (in_append) begin
            check("s_ready_in_append", s_ready, 1'b0);
            check("busy_in_append", busy, 1'b1);
        end
        if (m_valid && m_ready) begin
            check("sb_nonempty", sb8.size() != 0, 1'b1);
            if (sb8.size() != 0) begin
                e = sb8.pop_front();
                check("m_data", m_data, e[7:0]);
                check("m_last", m_last, e[8]);
                if (e[8] && in_append) in_append = 0;
            end
            pops8++;
        end
        acc = s_valid && s_ready;
        if (acc) begin
            sb8.push_back({sl && !cur_ap, sd});
            if (sl) begin
                post_last = 1;
                if (cur_ap) begin
                    inv = ~cur_reg;
                    sb8.push_back({1'b0, inv[31:24]});
                    sb8.push_back({1'b0, inv[23:16]});
                    sb8.push_back({1'b0, inv[15:8]});
                    sb8.push_back({1'b1, inv[7:0]});
                    in_append = 1;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic ap, input logic [31:0] exp_reg,
                                 input logic exp_ok, input logic exp_err, input int stall);
        logic acc;
        int   guard;
        cur_ap    = ap;
        cur_reg   = exp_reg;
        cur_ok    = exp_ok;
        cur_err   = exp_err;
        stall_pct = stall;
        ok_cnt    = 0;
        err_cnt   = 0;
        for (int i = 0; i < frame8.size(); i++) begin
            acc   = 1'b0;
            guard = 0;
            while (!acc && guard < 200) begin
                cycle8(1'b1, frame8[i], i == frame8.size() - 1, acc);
                guard++;
            end
            check("beat_accepted", acc, 1'b1);
        end
    endtask

    task automatic checkOutput(input int exp_ok_cnt, input int exp_err_cnt);
        logic acc;
        for (int g = 0; g < 200 && (sb8.size() != 0 || post_last); g++) begin
            cycle8(1'b0, 8'h00, 1'b0, acc);
        end
        check("drain_empty", sb8.size(), 0);
        cycle8(1'b0, 8'h00, 1'b0, acc);
        check("crc_idle_init", crc, INIT);
        check("busy_idle", busy, 1'b0);
        check("ok_pulse_count", ok_cnt, exp_ok_cnt);
        check("err_pulse_count", err_cnt, exp_err_cnt);
    endtask

    task automatic cycle32(input logic sv, input logic [31:0] sd, output logic acc);
        logic [32:0] e;
        @(negedge clk);
        w_s_valid = sv;
        w_s_data  = sd;
        w_s_last  = 1'b1;
        w_append  = 1'b1;
        w_m_ready = 1'b1;
        #1;
        if (w_m_valid && w_m_ready) begin
            check("w_sb_nonempty", sb32.size() != 0, 1'b1);
            if (sb32.size() != 0) begin
                e = sb32.pop_front();
                check("w_m_data", w_m_data, e[31:0]);
                check("w_m_last", w_m_last, e[32]);
            end
        end
        acc = w_s_valid && w_s_ready;
        if (acc) begin
            sb32.push_back({1'b0, sd});
            sb32.push_back({1'b1, ~ref_crc(INIT, sd, 32)});
        end
    endtask

    initial begin
        logic        acc;
        int          base;
        logic [31:0] model_reg;

        reset_n = 1'b0;
        s_valid = 0; s_data = 0; s_last = 0; append = 0; m_ready = 1;
        w_s_valid = 0; w_s_data = 0; w_s_last = 0; w_append = 0; w_m_ready = 1;
        cur_ap = 0; cur_reg = INIT; cur_ok = 0; cur_err = 0;
        stall_pct = 0; pops8 = 0; in_append = 0; post_last = 0;
        ok_cnt = 0; err_cnt = 0;

        #12;
        check("rst_crc", crc, INIT);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, 8'h00);
        check("rst_m_last", m_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_crc_ok", crc_ok, 1'b0);
        check("rst_crc_err", crc_err, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] append mode, 123456789, no stalls");
        frame8 = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        applyStimulus(1'b1, 32'h0376E6E7, 1'b0, 1'b0, 0);
        checkOutput(0, 0);

        $display("[TB] check mode, good frame with CRC");
        frame8 = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                  8'hFC, 8'h89, 8'h19, 8'h18};
        applyStimulus(1'b0, RESIDUE, CHECK_EN, 1'b0, 0);
        checkOutput(CHECK_EN ? 1 : 0, 0);

        $display("[TB] check mode, corrupted frame");
        frame8[4] = 8'h34;
        model_reg = ref_frame();
        applyStimulus(1'b0, model_reg, 1'b0, CHECK_EN, 0);
        checkOutput(0, CHECK_EN ? 1 : 0);

        $display("[TB] append mode with random output stalls");
        frame8 = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        applyStimulus(1'b1, 32'h0376E6E7, 1'b0, 1'b0, 40);
        checkOutput(0, 0);
        stall_pct = 0;

        $display("[TB] reset during second appended beat");
        base = pops8;
        applyStimulus(1'b1, 32'h0376E6E7, 1'b0, 1'b0, 0);
        for (int g = 0; g < 50 && pops8 < base + 10; g++) cycle8(1'b0, 8'h00, 1'b0, acc);
        check("reached_second_crc_beat", pops8, base + 10);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_m_valid", m_valid, 1'b0);
        check("mid_rst_m_data", m_data, 8'h00);
        check("mid_rst_m_last", m_last, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_crc", crc, INIT);
        sb8.delete();
        in_append = 0;
        post_last = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle8(1'b0, 8'h00, 1'b0, acc);
            check("no_stale_beat", m_valid, 1'b0);
        end
        applyStimulus(1'b1, 32'h0376E6E7, 1'b0, 1'b0, 0);
        checkOutput(0, 0);

        $display("[TB] 32-bit beats, single-beat append frame");
        acc = 1'b0;
        for (int g = 0; g < 20 && !acc; g++) cycle32(1'b1, 32'h31323334, acc);
        check("w_beat_accepted", acc, 1'b1);
        for (int g = 0; g < 20 && sb32.size() != 0; g++) cycle32(1'b0, 32'h0, acc);
        check("w_drain_empty", sb32.size(), 0);
        cycle32(1'b0, 32'h0, acc);
        check("w_m_valid_idle", w_m_valid, 1'b0);
        check("w_busy_idle", w_busy, 1'b0);
        check("w_crc_idle", w_crc, INIT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/crc_engine.md
CRC_ENGINE -- requirements
Module: crc_engine

Interface
REQ-001 The block SHALL take these parameters: CRC_W, default 32, CRC register width.
REQ-002 The block SHALL take DATA_W, default 8, beat width; CRC_W % DATA_W == 0 is required.
REQ-003 The block SHALL take POLY, default 32'h04C11DB7, generator polynomial without the implicit x^CRC_W term.
REQ-004 The block SHALL take INIT, default all ones, start-of-frame register value.
REQ-005 The block SHALL take RESIDUE, default 32'hC704DD7B, register value for a good frame including its CRC.
REQ-006 The block SHALL have these ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- s_valid, s_ready  in/out  1  input beat handshake.
- s_data  in  DATA_W  input beat.
- s_last  in  1  final beat of the frame.
- append  in  1  mode: 1 appends the CRC, 0 passes the frame through for checking; sampled on the first beat.
- m_valid, m_ready  out/in  1  output beat handshake.
- m_data  out  DATA_W  output beat.
- m_last  out  1  final output beat.
- crc  out  CRC_W  current register value.
- busy  out  1  mid-frame.
- crc_ok, crc_err  out  1  check result pulses (macro-dependent, see Configuration).

Function
REQ-007 A beat SHALL transfer when valid && ready on a rising clk edge; neither side may drop valid before transfer.
REQ-008 Registers SHALL update MSB-first and non-reflected: each accepted s_data is XORed into the top DATA_W bits, then DATA_W shifts through POLY are applied, all in one cycle.
REQ-009 The output SHALL be a single registered stage; s_ready = (state != APPEND) && (!m_valid || m_ready).
REQ-010 An accepted s_data SHALL appear on m_data the next cycle, giving a latency of 1.
REQ-011 The FSM SHALL have the states IDLE, PASS and APPEND.
REQ-012 In IDLE, crc == INIT; the first accepted beat latches the mode and moves the FSM to PASS, or stays in IDLE if s_last is also set and append == 0.
REQ-013 In PASS, an accepted beat with s_last goes to APPEND if append mode is latched, otherwise to IDLE with crc reloaded to INIT one cycle after the result is evaluated.
REQ-014 In append mode, m_last SHALL NOT be set on the data beat that carried s_last.
REQ-015 In APPEND, the block SHALL emit CRC_W/DATA_W beats of ~crc, most significant chunk first.
REQ-016 In APPEND, m_last SHALL be set on the final beat; the chunk counter advances only on an m handshake.
REQ-017 After the final APPEND beat, the FSM SHALL return to IDLE with crc = INIT.
REQ-018 In check mode, m_last SHALL mirror s_last.
REQ-019 Back-pressure (m_ready = 0) SHALL freeze m_data, m_last, the counter and crc.
REQ-020 busy SHALL be 1 in PASS and APPEND.
REQ-021 A single-beat frame in append mode SHALL be legal.
REQ-022 The next frame's first beat SHALL be accepted in the cycle after the last APPEND handshake, with no idle gap required beyond that.

Reset
REQ-023 Asserting reset_n low SHALL, asynchronously: state = IDLE, crc = INIT, m_valid = 0, m_data = 0, m_last = 0, counter = 0, busy = 0, crc_ok = crc_err = 0.
REQ-024 A reset mid-frame or mid-APPEND SHALL discard the frame; no partial-CRC beats are emitted after release.
REQ-025 Deassertion SHALL be synchronised externally; the first handshake is permitted the cycle after release.

Configuration
REQ-026 With CRC_ENGINE_CHECK_EN defined, crc_ok or crc_err SHALL pulse for one cycle after a check-mode s_last beat, according to whether the updated crc == RESIDUE.
REQ-027 Without CRC_ENGINE_CHECK_EN, crc_ok and crc_err SHALL be tied to 0 and no compare logic is built.

Structure
REQ-028 A package crc_engine_pkg SHALL hold the FSM state enum, the CRC-32 POLY, INIT and RESIDUE constants, and a function computing one DATA_W-bit update of a CRC_W register.
REQ-029 A sub-module crc_engine_step SHALL hold the combinational DATA_W-bit update, parametrised by CRC_W, DATA_W and POLY.
REQ-030 The FSM, output register and append counter SHALL live in crc_engine.

Verification
REQ-031 The bench SHALL cover these scenarios:
- Append, ASCII "123456789", m_ready = 1 -> output is those 9 bytes, then FC 89 19 18, m_last on 18; crc = 0376E6E7 before APPEND.
- Check mode, same 13 bytes with CRC_ENGINE_CHECK_EN -> crc_ok pulses once; crc_err = 0; crc = C704DD7B at the last beat.
- Check mode, one data bit flipped -> crc_err pulses; crc_ok = 0.
- Random m_ready stalls during "123456789" in append mode -> byte stream identical to the no-stall case, no beat lost or duplicated, s_ready = 0 throughout APPEND.
- reset_n low during the second APPEND beat, then the frame is resent -> no stale CRC beats; correct FC 89 19 18 appended.
- DATA_W = 32, single-beat append frame 0x31323334 -> exactly one CRC beat follows with m_last, and its value matches the software model.
